// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - decode-stage initiator for the FPU start/busy/done handshake
// Latches one FP instruction, pulses fpu_start, waits for fpu_done, then writes the FP register file.
module fpu_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [OPW-1:0]  issue_op,
    input  logic [4:0]      issue_rd,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [XLEN-1:0] issue_rs2,
    input  logic [XLEN-1:0] issue_rs3,
    input  logic            flush,
    output logic            fpu_start,
    output logic [OPW-1:0]  fpu_opcode,
    output logic [XLEN-1:0] fpu_inp1,
    output logic [XLEN-1:0] fpu_inp2,
    output logic [XLEN-1:0] fpu_inp3,
    input  logic            fpu_busy,
    input  logic            fpu_done,
    input  logic [XLEN-1:0] fpu_out,
    output logic            fp_we,
    output logic [4:0]      fp_waddr,
    output logic [XLEN-1:0] fp_wdata,
    output logic            stall,
    output logic            err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } issueState_e;

    issueState_e     stateQ;
    issueState_e     stateD;
    logic [OPW-1:0]  opQ;
    logic [4:0]      rdQ;
    logic [XLEN-1:0] rs1Q;
    logic [XLEN-1:0] rs2Q;
    logic [XLEN-1:0] rs3Q;
    logic [XLEN-1:0] resQ;
    logic [CW-1:0]   cntQ;
    logic [CW-1:0]   cntNext;
    logic            discardQ;
    logic            errQ;

    logic            acceptNow;
    logic            startNow;
    logic            writeNow;
    logic            doneNow;
    logic            timeoutHit;
    logic            readyNow;

    // Saturating wait counter; timeout fires in the WAIT cycle that would bring it to TIMEOUT.
    assign cntNext = (cntQ == CW'(TIMEOUT)) ? cntQ : cntQ + CW'(1);

    always_comb begin
        stateD     = stateQ;
        readyNow   = 1'b0;
        acceptNow  = 1'b0;
        startNow   = 1'b0;
        writeNow   = 1'b0;
        doneNow    = 1'b0;
        timeoutHit = 1'b0;
        case (stateQ)
            IDLE: begin
                readyNow  = !flush;
                acceptNow = issue_valid && !flush;
                if (acceptNow) begin
                    stateD = START;
                end
            end
            START: begin
                startNow = !fpu_busy;
                if (!fpu_busy) begin
                    stateD = WAIT;
                end
            end
            WAIT: begin
                if (fpu_done) begin
                    doneNow = 1'b1;
                    stateD  = (discardQ || flush) ? IDLE : WRITE;
                end else if (cntNext == CW'(TIMEOUT)) begin
                    timeoutHit = 1'b1;
                    stateD     = IDLE;
                end
            end
            WRITE: begin
                writeNow = 1'b1;
                stateD   = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stateQ   <= IDLE;
            opQ      <= '0;
            rdQ      <= '0;
            rs1Q     <= '0;
            rs2Q     <= '0;
            rs3Q     <= '0;
            resQ     <= '0;
            cntQ     <= '0;
            discardQ <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (acceptNow) begin
                opQ      <= issue_op;
                rdQ      <= issue_rd;
                rs1Q     <= issue_rs1;
                rs2Q     <= issue_rs2;
                rs3Q     <= issue_rs3;
                discardQ <= 1'b0;
            end
            // The FPU cannot be aborted, so a flush only suppresses the eventual write.
            if ((stateQ == START || stateQ == WAIT) && flush) begin
                discardQ <= 1'b1;
            end
            if (startNow) begin
                cntQ <= '0;
            end else if (stateQ == WAIT) begin
                cntQ <= cntNext;
            end
            if (doneNow) begin
                resQ <= fpu_out;
            end
            if (timeoutHit) begin
                errQ <= 1'b1;
            end
        end
    end

    // Strobes are masked while reset is asserted so nothing leaks out during the reset cycle.
    assign issue_ready = readyNow && !rst_n;
    assign fpu_start   = startNow && !rst_n;
    assign fp_we       = writeNow && !rst_n;
    assign stall       = (stateQ != IDLE) && !rst_n;

    assign fpu_opcode  = opQ;
    assign fpu_inp1    = rs1Q;
    assign fpu_inp2    = rs2Q;
    assign fpu_inp3    = rs3Q;
    assign fp_waddr    = rdQ;
    assign fp_wdata    = resQ;
    assign err_timeout = errQ;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid;
    logic            issue_ready;
    logic [OPW-1:0]  issue_op;
    logic [4:0]      issue_rd;
    logic [XLEN-1:0] issue_rs1, issue_rs2, issue_rs3;
    logic            flush;
    logic            fpu_start;
    logic [OPW-1:0]  fpu_opcode;
    logic [XLEN-1:0] fpu_inp1, fpu_inp2, fpu_inp3;
    logic            fpu_busy;
    logic            fpu_done;
    logic [XLEN-1:0] fpu_out;
    logic            fp_we;
    logic [4:0]      fp_waddr;
    logic [XLEN-1:0] fp_wdata;
    logic            stall;
    logic            err_timeout;

    int checkCount = 0;
    int failCount  = 0;
    int startCnt   = 0;
    int weCnt      = 0;
    int s0, w0;

    fpu_issue_ctrl #(.XLEN(XLEN), .OPW(OPW), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
        .flush(flush),
        .fpu_start(fpu_start), .fpu_opcode(fpu_opcode),
        .fpu_inp1(fpu_inp1), .fpu_inp2(fpu_inp2), .fpu_inp3(fpu_inp3),
        .fpu_busy(fpu_busy), .fpu_done(fpu_done), .fpu_out(fpu_out),
        .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
        .stall(stall), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fpu_start) startCnt <= startCnt + 1;
        if (fp_we)     weCnt    <= weCnt + 1;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rd = '0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0; flush = 1'b0;
        fpu_busy = 1'b0; fpu_done = 1'b0; fpu_out = '0;

        // reset state
        tick; #1;
        checkVal("rst_ready", issue_ready, 0);
        checkVal("rst_stall", stall, 0);
        checkVal("rst_start", fpu_start, 0);
        checkVal("rst_we", fp_we, 0);
        checkVal("rst_err", err_timeout, 0);
        checkVal("rst_opcode", fpu_opcode, 0);
        tick; rst_n = 1'b0; #1;
        checkVal("idle_ready", issue_ready, 1);

        // basic op: accept t, done t+4, write t+5
        tick;
        issue_valid = 1; issue_op = 3; issue_rd = 5;
        issue_rs1 = 32'h3F800000; issue_rs2 = 32'hAAAA0001; issue_rs3 = 32'h00005555; #1;
        checkVal("basic_ready", issue_ready, 1);
        s0 = startCnt; w0 = weCnt;
        tick; issue_valid = 0; #1;
        checkVal("basic_start", fpu_start, 1);
        checkVal("basic_stall", stall, 1);
        checkVal("basic_op", fpu_opcode, 3);
        checkVal("basic_inp1", fpu_inp1, 32'h3F800000);
        checkVal("basic_inp2", fpu_inp2, 32'hAAAA0001);
        checkVal("basic_inp3", fpu_inp3, 32'h00005555);
        tick; #1;
        checkVal("basic_start_once", fpu_start, 0);
        tick;
        tick; fpu_done = 1; fpu_out = 32'h40000000; #1;
        checkVal("basic_no_early_we", fp_we, 0);
        tick; fpu_done = 0; #1;
        checkVal("basic_we", fp_we, 1);
        checkVal("basic_waddr", fp_waddr, 5);
        checkVal("basic_wdata", fp_wdata, 32'h40000000);
        checkVal("basic_stall_write", stall, 1);
        tick; #1;
        checkVal("basic_stall_fall", stall, 0);
        checkVal("basic_we_off", fp_we, 0);
        checkVal("basic_ready_again", issue_ready, 1);
        checkVal("basic_start_count", startCnt - s0, 1);
        checkVal("basic_we_count", weCnt - w0, 1);

        // busy hold: busy t+1..t+3, stale done at t+2, start at t+4
        tick;
        issue_valid = 1; issue_op = 7; issue_rd = 12;
        issue_rs1 = 32'h11111111; issue_rs2 = 32'h22222222; issue_rs3 = 32'h33333333;
        fpu_busy = 1;
        tick; issue_valid = 0; issue_rs1 = 32'hDEADBEEF; issue_rs2 = 32'hDEADBEEF; #1;
        checkVal("busy_start1", fpu_start, 0);
        checkVal("busy_inp1_hold", fpu_inp1, 32'h11111111);
        tick; fpu_done = 1; fpu_out = 32'hFFFFFFFF; #1;
        checkVal("busy_start2", fpu_start, 0);
        checkVal("busy_stall", stall, 1);
        tick; fpu_done = 0; #1;
        checkVal("busy_start3", fpu_start, 0);
        checkVal("busy_op_hold", fpu_opcode, 7);
        tick; fpu_busy = 0; #1;
        checkVal("busy_start4", fpu_start, 1);
        checkVal("busy_inp1_at_start", fpu_inp1, 32'h11111111);
        checkVal("busy_inp3_at_start", fpu_inp3, 32'h33333333);
        tick; fpu_done = 1; fpu_out = 32'h12345678; fpu_busy = 1; #1;
        checkVal("busy_no_early_we", fp_we, 0);
        checkVal("busy_inp2_wait", fpu_inp2, 32'h22222222);
        tick; fpu_done = 0; fpu_busy = 0; #1;
        checkVal("busy_we", fp_we, 1);
        checkVal("busy_waddr", fp_waddr, 12);
        checkVal("busy_wdata", fp_wdata, 32'h12345678);
        tick; #1;
        checkVal("busy_stall_fall", stall, 0);

        // flush in WAIT: no write
        tick;
        issue_valid = 1; issue_op = 2; issue_rd = 9; issue_rs1 = 32'h01020304;
        w0 = weCnt;
        tick; issue_valid = 0; #1;
        checkVal("flw_start", fpu_start, 1);
        tick; flush = 1; #1;
        checkVal("flw_stall", stall, 1);
        tick; flush = 0;
        tick; fpu_done = 1; fpu_out = 32'hCAFEF00D;
        tick; fpu_done = 0; #1;
        checkVal("flw_no_we", fp_we, 0);
        checkVal("flw_stall_fall", stall, 0);
        checkVal("flw_ready", issue_ready, 1);
        tick; #1;
        checkVal("flw_we_count", weCnt - w0, 0);

        // flush at accept
        tick;
        s0 = startCnt;
        issue_valid = 1; flush = 1; issue_op = 5; #1;
        checkVal("fla_ready", issue_ready, 0);
        tick; issue_valid = 0; flush = 0; #1;
        checkVal("fla_stall", stall, 0);
        checkVal("fla_start", fpu_start, 0);
        checkVal("fla_op_kept", fpu_opcode, 2);
        tick; #1;
        checkVal("fla_start_count", startCnt - s0, 0);

        // timeout with TIMEOUT=8
        tick;
        issue_valid = 1; issue_op = 1; issue_rd = 3;
        w0 = weCnt;
        tick; issue_valid = 0; #1;
        checkVal("to_start", fpu_start, 1);
        for (int i = 0; i < 7; i++) tick;
        tick; #1;
        checkVal("to_err_before", err_timeout, 0);
        checkVal("to_stall_last_wait", stall, 1);
        tick; #1;
        checkVal("to_err_set", err_timeout, 1);
        checkVal("to_stall_fall", stall, 0);
        checkVal("to_no_we", fp_we, 0);
        tick; fpu_done = 1; fpu_out = 32'h0BADBAD0;
        tick; fpu_done = 0; #1;
        checkVal("to_late_done_we", fp_we, 0);
        checkVal("to_err_sticky", err_timeout, 1);
        checkVal("to_late_stall", stall, 0);
        checkVal("to_we_count", weCnt - w0, 0);

        // reset mid-op, then a normal issue
        tick;
        issue_valid = 1; issue_op = 6; issue_rd = 20; issue_rs1 = 32'hA5A5A5A5;
        tick; issue_valid = 0;
        tick;
        tick; rst_n = 1; #1;
        checkVal("rmid_ready_in_rst", issue_ready, 0);
        checkVal("rmid_stall_in_rst", stall, 0);
        tick; rst_n = 0; #1;
        checkVal("rmid_stall", stall, 0);
        checkVal("rmid_err_clr", err_timeout, 0);
        checkVal("rmid_op", fpu_opcode, 0);
        checkVal("rmid_inp1", fpu_inp1, 0);
        checkVal("rmid_wdata", fp_wdata, 0);
        checkVal("rmid_ready", issue_ready, 1);
        tick;
        issue_valid = 1; issue_op = 4; issue_rd = 31; issue_rs1 = 32'h40400000;
        tick; issue_valid = 0; #1;
        checkVal("post_start", fpu_start, 1);
        tick; fpu_done = 1; fpu_out = 32'h40800000;
        tick; fpu_done = 0; #1;
        checkVal("post_we", fp_we, 1);
        checkVal("post_waddr", fp_waddr, 31);
        checkVal("post_wdata", fp_wdata, 32'h40800000);
        tick; #1;
        checkVal("post_stall_fall", stall, 0);
        checkVal("post_err", err_timeout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Initiator side of the FPU start/busy/done handshake, placed in the decode stage between the instruction decoder and the floating-point unit. It accepts one decoded FP instruction and its operands, then issues a single start pulse to the FPU. It holds the operands stable, waits for completion, and writes the result back to the FP register file. While an operation is outstanding it asserts a pipeline stall, discards results on flush, and flags an FPU that never answers.

## Interface
- XLEN, 32, operand/result width
- OPW, 4, FPU opcode width
- TIMEOUT, 64, maximum WAIT cycles allowed for fpu_done after the start pulse (≥2)
- clk  in  1  clock
- rst_n  in  1  one clock; reset is synchronous and active-high (asserted = 1, sampled on rising clk)
- issue_valid  in  1  decoder presents an FP instruction
- issue_ready  out  1  controller accepts; transfer when issue_valid & issue_ready
- issue_op  in  OPW  FPU operation
- issue_rd  in  5  FP destination register
- issue_rs1, issue_rs2, issue_rs3  in  XLEN each  operand data
- flush  in  1  pipeline flush (PCSrcE)
- fpu_start  out  1  one-cycle start pulse
- fpu_opcode  out  OPW  latched op
- fpu_inp1, fpu_inp2, fpu_inp3  out  XLEN each  latched operands
- fpu_busy  in  1  FPU occupied
- fpu_done  in  1  one-cycle completion pulse
- fpu_out  in  XLEN  FPU result, valid with fpu_done
- fp_we  out  1  FP register-file write strobe
- fp_waddr  out  5  write address
- fp_wdata  out  XLEN  write data
- stall  out  1  to hazard unit (StallF/StallD)
- err_timeout  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, START, WAIT, WRITE.
- IDLE
  - issue_ready = 1 unless flush = 1 or reset is asserted.
  - On transfer: latch op, rd, and the three operands; clear the discard flag; go to START.
- START
  - fpu_start = 1 only when fpu_busy = 0; then go to WAIT and clear the wait counter.
  - While fpu_busy = 1: remain in START with fpu_start = 0.
  - fpu_done seen in START is stale and ignored.
- WAIT
  - Counter increments each cycle.
  - On fpu_done: capture fpu_out. Go to WRITE, or to IDLE if the discard flag is set.
  - If the counter reaches TIMEOUT without fpu_done: set err_timeout, go to IDLE, no write.
  - If fpu_done and timeout occur in the same cycle, done wins.
- WRITE
  - fp_we = 1 for exactly one cycle, with fp_waddr/fp_wdata from the latches; then go to IDLE.
- flush
  - In IDLE it blocks acceptance.
  - In START or WAIT it sets the discard flag. The FPU cannot be aborted, so the sequence still waits for done, but no write is performed.
  - In WRITE it has no effect; the write completes.
- stall = (state != IDLE), combinational from the state register.
- fpu_opcode and fpu_inp1..3 hold the latched values from acceptance until the next acceptance; they never change during START or WAIT.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- err_timeout clears only on reset.

## Timing
- Reset values:
  - State is IDLE.
  - fpu_start, fp_we, err_timeout, fp_waddr, fp_wdata, fpu_opcode, fpu_inp1..3, and the counter are all 0.
  - issue_ready = 0 and stall = 0 during the reset cycle.
- Latency: accept at cycle t; fpu_start at t+1 if the FPU is not busy. For fpu_done at t+1+k (k ≥ 1), fp_we occurs at t+2+k.
- Earliest next acceptance is the cycle after WRITE, i.e. t+3+k.
- stall rises at t+1 and falls in the cycle after WRITE (or after a discarded or timed-out WAIT).
- Reset mid-operation: return to IDLE on the next edge with no write. The pending result is lost; the FPU is reset concurrently.

## Test plan
- Basic op: accept op=3, rd=5, rs1=0x3F800000 at t; FPU done at t+4 with 0x40000000 -> fpu_start at t+1 only, fp_we=1, fp_waddr=5, fp_wdata=0x40000000 at t+5; stall high t+1..t+5.
- Busy hold: fpu_busy=1 for 3 cycles after accept -> fpu_start delayed to t+4; operands unchanged throughout.
- Flush in WAIT: flush pulse at t+2, done at t+4 -> no fp_we; IDLE at t+5; issue_ready=1.
- Timeout: TIMEOUT=8, no done -> err_timeout=1 after 8 WAIT cycles, no write, IDLE. Then a late fpu_done is ignored; err_timeout stays high until reset.
- Flush at accept: issue_valid=1 with flush=1 -> issue_ready=0, no transfer, no fpu_start.
- Reset mid-op: rst_n=1 during WAIT -> all outputs 0 next cycle; a following issue completes normally.
